// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage: command encodings,
// command width and the stage FSM state type.
package exe_pkg;

  localparam int EXE_CMD_LEN = 4;

  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD  = 4'd0;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SUB  = 4'd1;
  localparam logic [EXE_CMD_LEN-1:0] EXE_AND  = 4'd2;
  localparam logic [EXE_CMD_LEN-1:0] EXE_OR   = 4'd3;
  localparam logic [EXE_CMD_LEN-1:0] EXE_NOR  = 4'd4;
  localparam logic [EXE_CMD_LEN-1:0] EXE_XOR  = 4'd5;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLL  = 4'd6;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRL  = 4'd7;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SRA  = 4'd8;
  localparam logic [EXE_CMD_LEN-1:0] EXE_SLT  = 4'd9;
  localparam logic [EXE_CMD_LEN-1:0] EXE_MUL  = 4'd10;
  localparam logic [EXE_CMD_LEN-1:0] EXE_PASS = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } exe_state_t;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier returning the low WIDTH bits of op_a*op_b.
// One iteration per cycle; only built into exe_stage_mc when EXE_MUL_EN is defined.
module exe_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_LEN = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_LEN-1:0] LAST_CNT = CNT_LEN'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   acc_sum;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic               run_q, run_d;

  // The product is ready combinationally during the last iteration.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = run_q && (cnt_q == LAST_CNT);
  assign product = acc_sum;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST_CNT) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage with operand forwarding and a valid/ready result port.
// Define EXE_MUL_EN to build the iterative multiplier; otherwise MUL is illegal.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_FWD   = 2,
  parameter int SEL_LEN   = $clog2(NUM_FWD + 1),
  parameter int SHAMT_LEN = $clog2(WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXE_CMD_LEN-1:0]   exe_cmd,
  input  logic [SEL_LEN-1:0]       val1_sel,
  input  logic [SEL_LEN-1:0]       val2_sel,
  input  logic [SEL_LEN-1:0]       st_sel,
  input  logic [WIDTH-1:0]         val1,
  input  logic [WIDTH-1:0]         val2,
  input  logic [WIDTH-1:0]         st_value_in,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic [SHAMT_LEN-1:0]     shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         alu_result,
  output logic [WIDTH-1:0]         st_value_out,
  output logic                     illegal_cmd,
  output logic                     busy
);

  logic [2:0][WIDTH-1:0]   own_val;
  logic [2:0][SEL_LEN-1:0] sel_val;
  logic [2:0][WIDTH-1:0]   picked;
  logic [WIDTH-1:0]        op1, op2, st_pick;

  assign own_val = {st_value_in, val2, val1};
  assign sel_val = {st_sel, val2_sel, val1_sel};

  // Selects above NUM_FWD match no source and fall through to the own value.
  for (genvar o = 0; o < 3; o++) begin : g_fwd_mux
    logic [WIDTH-1:0] pick;
    always_comb begin
      pick = own_val[o];
      for (int k = 1; k <= NUM_FWD; k++) begin
        if (sel_val[o] == SEL_LEN'(k)) pick = fwd_data[k*WIDTH-1 -: WIDTH];
      end
    end
    assign picked[o] = pick;
  end

  assign op1     = picked[0];
  assign op2     = picked[1];
  assign st_pick = picked[2];

  logic [WIDTH-1:0] alu_value;
  logic             alu_illegal;

  always_comb begin
    alu_value   = '0;
    alu_illegal = 1'b0;
    case (exe_cmd)
      EXE_ADD:  alu_value = op1 + op2;
      EXE_SUB:  alu_value = op1 - op2;
      EXE_AND:  alu_value = op1 & op2;
      EXE_OR:   alu_value = op1 | op2;
      EXE_NOR:  alu_value = ~(op1 | op2);
      EXE_XOR:  alu_value = op1 ^ op2;
      EXE_SLL:  alu_value = op2 << shamt;
      EXE_SRL:  alu_value = op2 >> shamt;
      EXE_SRA:  alu_value = $signed(op2) >>> shamt;
      EXE_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      EXE_PASS: alu_value = op1;
      default:  alu_illegal = 1'b1;
    endcase
  end

  exe_state_t state_q, state_d;
  logic       accept, take, take_mul, mul_done;

  // A flushed accept is treated as if the command never arrived.
  assign accept = in_valid && in_ready;
  assign take   = accept && !flush;

`ifdef EXE_MUL_EN
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] st_pend_q, st_pend_d;

  assign take_mul = take && (exe_cmd == EXE_MUL);

  exe_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst),
    .start   (take_mul),
    .op_a    (op1),
    .op_b    (op2),
    .abort   (flush),
    .done    (mul_done),
    .product (mul_product)
  );

  assign st_pend_d = take_mul ? st_pick : st_pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_pend_q <= '0;
    else      st_pend_q <= st_pend_d;
  end
`else
  assign take_mul = 1'b0;
  assign mul_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (take) state_d = take_mul ? MUL : HOLD;
        MUL:  if (mul_done) state_d = HOLD;
        HOLD: begin
          if (take)           state_d = take_mul ? MUL : HOLD;
          else if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // HOLD may accept in the same cycle its result drains.
  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q != MUL) && (!out_valid || out_ready);
`ifdef EXE_MUL_EN
    busy      = (state_q == MUL);
`else
    busy      = 1'b0;
`endif
  end

  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] st_value_q, st_value_d;
  logic             illegal_q, illegal_d;

  always_comb begin
    alu_result_d = alu_result_q;
    st_value_d   = st_value_q;
    illegal_d    = illegal_q;
    if (take && !take_mul) begin
      alu_result_d = alu_value;
      st_value_d   = st_pick;
      illegal_d    = alu_illegal;
    end
`ifdef EXE_MUL_EN
    else if (!flush && (state_q == MUL) && mul_done) begin
      alu_result_d = mul_product;
      st_value_d   = st_pend_q;
      illegal_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q <= '0;
      st_value_q   <= '0;
      illegal_q    <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      st_value_q   <= st_value_d;
      illegal_q    <= illegal_d;
    end
  end

  assign alu_result   = alu_result_q;
  assign st_value_out = st_value_q;
  assign illegal_cmd  = illegal_q;

endmodule
